// File: rtl/gain_ramp_pkg.sv
// Shared definitions for the gain ramp and the multiplier stage it feeds: gain code range,
// FSM state encoding and the effective-target helper.
package gain_ramp_pkg;

    localparam int unsigned GAIN_W   = 4;
    localparam int unsigned GAIN_MAX = 10;

    typedef logic [GAIN_W-1:0] gain_t;

    localparam gain_t GainMaxCode = gain_t'(GAIN_MAX);

    typedef enum logic {
        StIdle = 1'b0,
        StRamp = 1'b1
    } ramp_state_e;

    // Mute forces the target to 0; otherwise requests above the legal range are clamped.
    function automatic gain_t eff_target(input gain_t tgt, input logic mute);
        if (mute) begin
            return '0;
        end
        return (tgt > GainMaxCode) ? GainMaxCode : tgt;
    endfunction

endpackage

// File: rtl/gain_ramp_if.sv
// Control/status bundle between the gain-ramp controller and whoever drives it.
interface gain_ramp_if;
    import gain_ramp_pkg::*;

    logic  sample_tick;
    gain_t target_gain;
    logic  mute;
    gain_t gain_code;
    logic  ramping;
    logic  muted;
    logic  step_pulse;

    modport master (
        output sample_tick, target_gain, mute,
        input  gain_code, ramping, muted, step_pulse
    );

    modport slave (
        input  sample_tick, target_gain, mute,
        output gain_code, ramping, muted, step_pulse
    );

endinterface

// File: rtl/gain_ramp_hold_cnt.sv
// Sample-tick hold counter: counts 0..HOLD_SAMPLES-1 on enabled ticks and wraps to 0 after the
// terminal count. Clear has priority over enable.
module gain_ramp_hold_cnt #(
    parameter int unsigned HOLD_SAMPLES = 480,
    parameter int unsigned CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == CNT_W'(HOLD_SAMPLES - 1));

    // Next count: clear, wrap at terminal count, or increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gain_ramp.sv
// Gain smoother: walks the applied gain code one LSB at a time toward the (clamped or muted)
// target, one step every HOLD_SAMPLES sample ticks, so the multiplier never sees a jump.
module gain_ramp
    import gain_ramp_pkg::*;
#(
    parameter int unsigned RESET_GAIN   = 0,
    parameter int unsigned HOLD_SAMPLES = 480,
    parameter int unsigned CNT_W        = 16
) (
    input logic       clk,
    input logic       rst,
    gain_ramp_if.slave bus
);

    ramp_state_e state_q;
    gain_t       gain_code_q;
    logic        step_pulse_q;

    gain_t eff_tgt;
    gain_t gain_step;
    logic  at_tgt;
    logic  hold_tc;

    assign eff_tgt   = eff_target(bus.target_gain, bus.mute);
    assign at_tgt    = (gain_code_q == eff_tgt);
    // Direction is re-evaluated at every step, so a reversal lands on the next step.
    assign gain_step = (eff_tgt > gain_code_q) ? gain_code_q + gain_t'(1)
                                               : gain_code_q - gain_t'(1);

    // Held at 0 while idle so every ramp starts with a full hold period.
    gain_ramp_hold_cnt #(
        .HOLD_SAMPLES (HOLD_SAMPLES),
        .CNT_W        (CNT_W)
    ) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == StIdle),
        .en_i  ((state_q == StRamp) && bus.sample_tick),
        .tc_o  (hold_tc)
    );

    // Ramp FSM, applied gain register and step strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            gain_code_q  <= gain_t'(RESET_GAIN);
            step_pulse_q <= 1'b0;
        end else begin
            step_pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!at_tgt) begin
                        state_q <= StRamp;
                    end
                end
                StRamp: begin
                    if (at_tgt) begin
                        // Target moved onto the current code without a step.
                        state_q <= StIdle;
                    end else if (bus.sample_tick && hold_tc) begin
                        gain_code_q  <= gain_step;
                        step_pulse_q <= 1'b1;
                        if (gain_step == eff_tgt) begin
                            state_q <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.gain_code  = gain_code_q;
    assign bus.ramping    = (state_q == StRamp);
    assign bus.step_pulse = step_pulse_q;
    assign bus.muted      = bus.mute && (gain_code_q == '0);

endmodule
